// File: rtl/aq_axi_pkg.sv
// Shared widths and FSM encodings for the AXI-style slave RAM.
package aq_axi_pkg;

    localparam int ADDR_W     = 28;
    localparam int DATA_W     = 128;
    localparam int STRB_W     = 16;
    localparam int LEN_W      = 4;
    localparam int ID_W       = 4;
    // addresses count 16-bit words; eight of them make one 128-bit beat
    localparam int WORD_SHIFT = 3;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_DATA = 1'b1
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_LAT  = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

endpackage

// File: rtl/aq_axi_slave_ram_if.sv
// Write-address, write-data, read-address and read-data signals of the slave RAM bus.
interface aq_axi_slave_ram_if;
    import aq_axi_pkg::*;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wready;
    logic              wlast;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rlast;

    modport master (
        output awid, awaddr, awlen, awvalid, wdata, wstrb,
        output arid, araddr, arlen, arvalid,
        input  awready, wready, wlast, arready, rdata, rvalid, rlast
    );

    modport slave (
        input  awid, awaddr, awlen, awvalid, wdata, wstrb,
        input  arid, araddr, arlen, arvalid,
        output awready, wready, wlast, arready, rdata, rvalid, rlast
    );

endinterface

// File: rtl/aq_axi_sdp_ram.sv
// Simple dual-port RAM: byte-enabled write port, one-cycle registered read-first read port.
module aq_axi_sdp_ram
    import aq_axi_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [MEM_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              re,
    input  logic [MEM_AW-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**MEM_AW];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Reading in a separate block sees the pre-write contents on a same-index collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/aq_axi_slave_ram.sv
// AXI-style slave RAM: independent single-outstanding write and read burst engines
// in front of a 128-bit simple dual-port RAM.
module aq_axi_slave_ram
    import aq_axi_pkg::*;
#(
    parameter int MEM_AW       = 10,
    parameter int READ_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    aq_axi_slave_ram_if.slave bus
);

    // state  | meaning
    // W_IDLE | awready high, waiting for a write address
    // W_DATA | one beat accepted and written per cycle, wlast on the final one
    // R_IDLE | arready high, waiting for a read address
    // R_LAT  | latency wait; its last cycle issues the first RAM read
    // R_DATA | one beat presented per cycle while the next one is read ahead

    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 2);

    w_state_t          w_state, w_state_nxt;
    r_state_t          r_state, r_state_nxt;
    logic              rst_done;

    logic [MEM_AW-1:0] w_base;
    logic [LEN_W-1:0]  w_len;
    logic [LEN_W-1:0]  w_beat;
    logic              aw_ready;
    logic              w_ready;
    logic              w_last;
    logic              aw_hs;

    logic [MEM_AW-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat;
    logic [3:0]        lat_cnt;
    logic              ar_ready;
    logic              r_valid;
    logic              r_last;
    logic              ar_hs;
    logic              rd_en;
    logic [LEN_W-1:0]  rd_off;

    logic              unused_bits;

    assign unused_bits = ^{bus.awid, bus.arid, bus.awaddr, bus.araddr};

    assign aw_hs = bus.awvalid && aw_ready;
    assign ar_hs = bus.arvalid && ar_ready;

    // Handshake ready is held off until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_done <= 1'b0;
        else     rst_done <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        unique case (w_state)
            W_IDLE: if (aw_hs) w_state_nxt = W_DATA;
            W_DATA: if (w_beat == w_len) w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        w_last   = 1'b0;
        if (w_state == W_IDLE) begin
            aw_ready = rst_done;
        end else begin
            w_ready = 1'b1;
            w_last  = (w_beat == w_len);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_base <= '0;
            w_len  <= '0;
            w_beat <= '0;
        end else if (aw_hs) begin
            w_base <= bus.awaddr[WORD_SHIFT +: MEM_AW];
            w_len  <= bus.awlen;
            w_beat <= '0;
        end else if (w_ready) begin
            w_beat <= w_last ? '0 : w_beat + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_LAT;
            R_LAT:   if (lat_cnt == 4'd0) r_state_nxt = R_DATA;
            R_DATA:  if (r_beat == r_len) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        r_last   = 1'b0;
        rd_en    = 1'b0;
        rd_off   = '0;
        unique case (r_state)
            R_IDLE: ar_ready = rst_done;
            R_LAT:  rd_en    = (lat_cnt == 4'd0);
            R_DATA: begin
                r_valid = 1'b1;
                r_last  = (r_beat == r_len);
                rd_en   = (r_beat != r_len);
                rd_off  = r_beat + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            lat_cnt <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: if (ar_hs) begin
                    r_base  <= bus.araddr[WORD_SHIFT +: MEM_AW];
                    r_len   <= bus.arlen;
                    r_beat  <= '0;
                    lat_cnt <= LAT_LOAD;
                end
                R_LAT:  if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 1'b1;
                R_DATA: r_beat <= r_last ? '0 : r_beat + 1'b1;
                default: ;
            endcase
        end
    end

    aq_axi_sdp_ram #(
        .MEM_AW (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_ready),
        .waddr (w_base + MEM_AW'(w_beat)),
        .wdata (bus.wdata),
        .wstrb (bus.wstrb),
        .re    (rd_en),
        .raddr (r_base + MEM_AW'(rd_off)),
        .rdata (bus.rdata)
    );

    assign bus.awready = aw_ready;
    assign bus.wready  = w_ready;
    assign bus.wlast   = w_last;
    assign bus.arready = ar_ready;
    assign bus.rvalid  = r_valid;
    assign bus.rlast   = r_last;

endmodule

// File: tb/tb_aq_axi_slave_ram.sv
// Bench for aq_axi_slave_ram: cycle-timeline reference model, per-cycle compare and directed cases.
`timescale 1ns/1ps
module tb_aq_axi_slave_ram;
    import aq_axi_pkg::*;

    localparam int AW    = 10;
    localparam int LAT   = 4;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [ADDR_W-1:0]             addr;
        logic [LEN_W-1:0]              len;
        logic [15:0][DATA_W-1:0]       data;
        logic [15:0][STRB_W-1:0]       strb;
    } wburst_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } rburst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aq_axi_slave_ram_if bus ();

    aq_axi_slave_ram #(.MEM_AW(AW), .READ_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model: interval n is the time between edge n and edge n+1
    wburst_t           wq[$];
    rburst_t           rq[$];
    wburst_t           w_act;
    logic [DATA_W-1:0] mdl_mem [DEPTH];
    longint            n = 0;
    longint            w_start = 0, w_end = -1, r_first = 0, r_end = -1;
    logic [AW-1:0]     w_base = '0, r_base = '0;
    logic              mdl_ready = 1'b0;
    logic              exp_awready = 1'b0, exp_wready = 1'b0, exp_wlast = 1'b0;
    logic              exp_arready = 1'b0, exp_rvalid = 1'b0, exp_rlast = 1'b0;
    logic [DATA_W-1:0] exp_rdata = '0;
    longint            aw_hs_log[$], ar_hs_log[$], rv_n_log[$];
    logic [DATA_W-1:0] rd_log[$];
    int                mk;
    int                dk;
    logic [AW-1:0]     midx;

    function automatic void chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, expv);
        end
    endfunction

    function automatic logic [DATA_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) begin
        n = n + 1;
        if (rst) begin
            w_start = 0; w_end = -1; r_first = 0; r_end = -1;
            mdl_ready = 1'b0;
            exp_rdata = '0;
        end else begin
            if (n >= r_first && n <= r_end) begin
                midx = r_base + AW'(n - r_first);
                exp_rdata = mdl_mem[midx];
            end
            if (exp_wready) begin
                mk = int'(n - 1 - w_start);
                midx = w_base + AW'(mk);
                for (int b = 0; b < STRB_W; b++)
                    if (w_act.strb[mk][b]) mdl_mem[midx][8*b +: 8] = w_act.data[mk][8*b +: 8];
            end
            if (bus.awvalid && exp_awready && wq.size() > 0) begin
                w_act   = wq.pop_front();
                w_start = n;
                w_end   = n + longint'(bus.awlen);
                w_base  = bus.awaddr[3 +: AW];
                aw_hs_log.push_back(n);
            end
            if (bus.arvalid && exp_arready && rq.size() > 0) begin
                void'(rq.pop_front());
                r_first = n + LAT - 1;
                r_end   = r_first + longint'(bus.arlen);
                r_base  = bus.araddr[3 +: AW];
                ar_hs_log.push_back(n);
            end
            mdl_ready = 1'b1;
        end
        exp_awready = mdl_ready && (n > w_end);
        exp_wready  = (n >= w_start) && (n <= w_end);
        exp_wlast   = (n == w_end);
        exp_arready = mdl_ready && (n > r_end);
        exp_rvalid  = (n >= r_first) && (n <= r_end);
        exp_rlast   = (n == r_end);
    end

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.awid = ID_W'($urandom);
            bus.arid = ID_W'($urandom);
            if (wq.size() > 0) begin
                bus.awvalid = 1'b1; bus.awaddr = wq[0].addr; bus.awlen = wq[0].len;
            end else begin
                bus.awvalid = 1'b0; bus.awaddr = ADDR_W'($urandom); bus.awlen = LEN_W'($urandom);
            end
            if (rq.size() > 0) begin
                bus.arvalid = 1'b1; bus.araddr = rq[0].addr; bus.arlen = rq[0].len;
            end else begin
                bus.arvalid = 1'b0; bus.araddr = ADDR_W'($urandom); bus.arlen = LEN_W'($urandom);
            end
            if (exp_wready) begin
                dk = int'(n - w_start);
                bus.wdata = w_act.data[dk];
                bus.wstrb = w_act.strb[dk];
            end else begin
                bus.wdata = rnd128();
                bus.wstrb = STRB_W'($urandom);
            end
        end
    end

    always @(negedge clk) begin
        chk("awready", DATA_W'(bus.awready), DATA_W'(rst ? 1'b0 : exp_awready));
        chk("wready",  DATA_W'(bus.wready),  DATA_W'(rst ? 1'b0 : exp_wready));
        chk("wlast",   DATA_W'(bus.wlast),   DATA_W'(rst ? 1'b0 : exp_wlast));
        chk("arready", DATA_W'(bus.arready), DATA_W'(rst ? 1'b0 : exp_arready));
        chk("rvalid",  DATA_W'(bus.rvalid),  DATA_W'(rst ? 1'b0 : exp_rvalid));
        chk("rlast",   DATA_W'(bus.rlast),   DATA_W'(rst ? 1'b0 : exp_rlast));
        if (rst || exp_rvalid) chk("rdata", bus.rdata, rst ? '0 : exp_rdata);
        if (bus.rvalid) begin
            rd_log.push_back(bus.rdata);
            rv_n_log.push_back(n);
        end
    end

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((wq.size() != 0 || rq.size() != 0 || n <= w_end || n <= r_end) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) begin
            total++; bad++;
            $display("FAIL idle_timeout: still busy after %0d cycles", budget);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic push_w(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                          input logic [DATA_W-1:0] d0, input logic [STRB_W-1:0] s0);
        wburst_t b;
        b.addr = a; b.len = l;
        for (int j = 0; j < 16; j++) begin
            b.data[j] = d0 + DATA_W'(j);
            b.strb[j] = s0;
        end
        wq.push_back(b);
    endtask

    task automatic push_r(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        rburst_t b;
        b.addr = a; b.len = l;
        rq.push_back(b);
    endtask

    task automatic check_log(input string name, input logic [DATA_W-1:0] expv[$]);
        chk({name, "_count"}, DATA_W'(rd_log.size()), DATA_W'(expv.size()));
        for (int i = 0; i < expv.size() && i < rd_log.size(); i++) chk(name, rd_log[i], expv[i]);
    endtask

    initial begin
        wburst_t           wb;
        logic [DATA_W-1:0] ev[$];
        int                c;

        // reset values
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", DATA_W'({bus.awready, bus.arready, bus.wready, bus.wlast, bus.rvalid, bus.rlast}), '0);
        chk("reset_rdata", bus.rdata, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", DATA_W'({bus.awready, bus.arready}), DATA_W'(2'b11));
        @(negedge clk);
        #1;

        // fill the whole memory so every later read has a known value
        for (int i = 0; i < DEPTH / 16; i++) begin
            wb.addr = ADDR_W'(i * 16) << 3;
            wb.len  = 4'd15;
            for (int j = 0; j < 16; j++) begin
                wb.data[j] = rnd128();
                wb.strb[j] = 16'hFFFF;
            end
            wq.push_back(wb);
        end
        wait_idle(2000);

        // short write then read
        push_w(28'h0, 4'd3, 128'h1, 16'hFFFF);
        wait_idle(100);
        chk("t1_model_mem3", mdl_mem[3], 128'h4);
        rd_log.delete(); rv_n_log.delete();
        push_r(28'h0, 4'd3);
        wait_idle(100);
        ev = '{128'h1, 128'h2, 128'h3, 128'h4};
        check_log("t1_rdata", ev);
        if (rv_n_log.size() > 0 && ar_hs_log.size() > 0)
            chk("t1_latency", DATA_W'(rv_n_log[0] - ar_hs_log[$]), DATA_W'(LAT - 1));
        else
            chk("t1_latency_seen", DATA_W'(rv_n_log.size()), DATA_W'(1));

        // back-to-back full write bursts at indices 16..47
        push_w(28'h80, 4'd15, 128'hB2B0_0010, 16'hFFFF);
        push_w(28'h100, 4'd15, 128'hB2B0_0020, 16'hFFFF);
        wait_idle(200);
        chk("t2_aw_gap", DATA_W'(aw_hs_log[$] - aw_hs_log[aw_hs_log.size() - 2]), DATA_W'(17));
        chk("t2_model_mem47", mdl_mem[47], 128'hB2B0_002F);
        rd_log.delete();
        push_r(28'h80, 4'd15);
        push_r(28'h100, 4'd15);
        wait_idle(200);
        ev.delete();
        for (int i = 16; i < 48; i++) ev.push_back(128'hB2B0_0000 + DATA_W'(i));
        check_log("t2_rdata", ev);

        // partial strobe at index 100
        push_w(28'(100 << 3), 4'd0, {DATA_W{1'b1}}, 16'hFFFF);
        push_w(28'(100 << 3), 4'd0, '0, 16'h00FF);
        wait_idle(100);
        rd_log.delete();
        push_r(28'(100 << 3), 4'd0);
        wait_idle(100);
        ev = '{128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000};
        check_log("t3_strobe", ev);

        // wrap past the top index; upper address bits ignored
        push_w(28'h800_0000 | 28'(1023 << 3), 4'd1, 128'hA0A0_0000, 16'hFFFF);
        wait_idle(100);
        chk("t4_model_mem0", mdl_mem[0], 128'hA0A0_0001);
        rd_log.delete();
        push_r(28'h0, 4'd0);
        push_r(28'(1023 << 3), 4'd1);
        wait_idle(100);
        ev = '{128'hA0A0_0001, 128'hA0A0_0000, 128'hA0A0_0001};
        check_log("t4_wrap", ev);

        // same-edge read and write of index 300
        push_w(28'(300 << 3), 4'd0, 128'h01D0_0000, 16'hFFFF);
        wait_idle(100);
        rd_log.delete();
        push_r(28'(300 << 3), 4'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        push_w(28'(300 << 3), 4'd0, 128'h0E40_0000, 16'hFFFF);
        wait_idle(100);
        ev = '{128'h01D0_0000};
        check_log("t5_collide_old", ev);
        rd_log.delete();
        push_r(28'(300 << 3), 4'd0);
        wait_idle(100);
        ev = '{128'h0E40_0000};
        check_log("t5_collide_new", ev);

        // reset during beat 2 of an 8-beat burst
        push_w(28'(200 << 3), 4'd7, 128'hEE00, 16'hFFFF);
        wait_idle(100);
        push_w(28'(200 << 3), 4'd7, 128'h0100, 16'hFFFF);
        c = 0;
        while (!(exp_wready && (n - w_start) == 2) && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c >= 100) begin
            total++; bad++;
            $display("FAIL t6_beat2_timeout: beat 2 never reached");
        end
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_ctrl", DATA_W'({bus.awready, bus.arready, bus.wready, bus.wlast, bus.rvalid, bus.rlast}), '0);
        chk("t6_rst_rdata", bus.rdata, '0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_awready_after", DATA_W'(bus.awready), DATA_W'(1'b1));
        @(negedge clk);
        #1;
        rd_log.delete();
        push_r(28'(200 << 3), 4'd7);
        wait_idle(100);
        ev = '{128'h0100, 128'h0101, 128'hEE02, 128'hEE03, 128'hEE04, 128'hEE05, 128'hEE06, 128'hEE07};
        check_log("t6_persist", ev);

        // random concurrent traffic against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                wb.addr = ADDR_W'($urandom);
                wb.len  = LEN_W'($urandom);
                for (int j = 0; j < 16; j++) begin
                    wb.data[j] = rnd128();
                    wb.strb[j] = STRB_W'($urandom);
                end
                wq.push_back(wb);
            end
            if ($urandom_range(0, 1) == 1) push_r(ADDR_W'($urandom), LEN_W'($urandom));
            repeat ($urandom_range(1, 12)) @(negedge clk);
            #1;
        end
        wait_idle(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
